arb_req_agent: RTL and testbench

Requester-side agent for the fixed-priority bus arbiter. It holds one master's bus request from command acceptance until the last data beat completes. It counts beats only while the grant is held, and releases the request for one cycle after each transaction so lower-priority masters can win. One instance sits between each master's command logic and its `req`/`grant` pair on the arbiter.

---
 rtl/arb_req_agent.sv | 128 ++++++++++++
 tb/tb_arb_req_agent.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_agent.sv
// arb_req_agent: holds one master's arbiter request from command accept to the last beat.
// Define ARB_REQ_TIMEOUT_EN to abandon commands whose grant never arrives.
module arb_req_agent #(
  parameter int LEN_W = 8,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             grant,
  input  logic             bus_ready,
  output logic             bus_en,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             last,
  output logic             done,
  output logic             timeout,
  output logic             busy
);
  // state | meaning
  // IDLE  | accepting a command
  // REQ   | request raised, waiting for grant
  // OWN   | transferring beats; grant may drop and return
  // GAP   | one-cycle request release so lower priorities can win
  typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q, len_d, beat_d;
  logic             req_d, done_d, timeout_d;
  logic             expired;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last      = (state == OWN) && (beat_cnt == len_q);
  assign bus_en    = (state == OWN) && grant && bus_ready;

`ifdef ARB_REQ_TIMEOUT_EN
  logic [TO_W-1:0] wait_cnt, wait_d;
  assign expired = (state == REQ) && !grant && (wait_cnt == {TO_W{1'b1}});
`else
  logic [TO_W-1:0] to_unused;
  assign to_unused = '0;
  assign expired   = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    req_d     = req;
    len_d     = len_q;
    beat_d    = beat_cnt;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
    wait_d    = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          len_d   = cmd_len;
          beat_d  = '0;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      REQ: begin
        // grant beats expiry when both land on the same cycle
        if (grant) begin
          state_d = OWN;
        end else if (expired) begin
          state_d   = GAP;
          req_d     = 1'b0;
          timeout_d = 1'b1;
        end
`ifdef ARB_REQ_TIMEOUT_EN
        if (!grant) wait_d = wait_cnt + TO_W'(1);
`endif
      end
      OWN: begin
        if (bus_en) begin
          if (last) begin
            state_d = GAP;
            req_d   = 1'b0;
            done_d  = 1'b1;
            beat_d  = '0;
          end else begin
            beat_d = beat_cnt + LEN_W'(1);
          end
        end
      end
      GAP: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      req      <= req_d;
      len_q    <= len_d;
      beat_cnt <= beat_d;
      done     <= done_d;
      timeout  <= timeout_d;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= wait_d;
  end
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: randomized and directed checks of arb_req_agent against a beat-level model.
// Timeout checks run only when ARB_REQ_TIMEOUT_EN is defined.
module tb_arb_req_agent;
  localparam int LEN_W = 8;
  localparam int TO_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             req, grant, bus_ready, bus_en;
  logic [LEN_W-1:0] beat_cnt;
  logic             last, done, timeout, busy;

  int total = 0;
  int bad   = 0;

  arb_req_agent #(.LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .req(req), .grant(grant), .bus_ready(bus_ready),
    .bus_en(bus_en), .beat_cnt(beat_cnt), .last(last), .done(done),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction, starting and ending at a negedge with the agent idle.
  // The expected beat index is just the number of beats seen transfer so far.
  task automatic run_txn(input int len, input int pg, input int pr,
                         input int hold_beat, input int hold_n, input bit hold_ready,
                         output int own_cycles);
    int k, waits, holds;
    bit g, r;
    chk_val("idle_ready", cmd_ready, 1);
    chk_val("idle_busy", busy, 0);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    grant     = 1'($urandom_range(1));
    @(negedge clk);
    cmd_valid = 1'($urandom_range(1));
    cmd_len   = LEN_W'($urandom);
    chk_val("acc_req", req, 1);
    chk_val("acc_busy", busy, 1);
    chk_val("acc_ready", cmd_ready, 0);
    chk_val("acc_cnt", beat_cnt, 0);
    waits = 0;
    do begin
      g = (waits >= 10) || ($urandom_range(99) < pg);
      grant = g;
      bus_ready = 1'($urandom_range(1));
      #1;
      chk_val("wait_busen", bus_en, 0);
      chk_val("wait_req", req, 1);
      chk_val("wait_last", last, 0);
      chk_val("wait_tmo", timeout, 0);
      @(negedge clk);
      waits++;
      cmd_valid = 1'($urandom_range(1));
      cmd_len   = LEN_W'($urandom);
    end while (!g);
    k = 0; holds = 0; own_cycles = 0;
    while (k <= len && own_cycles < 300) begin
      g = ($urandom_range(99) < pg);
      r = ($urandom_range(99) < pr);
      if (k == hold_beat && holds < hold_n) begin
        if (hold_ready) r = 1'b0; else g = 1'b0;
        holds++;
      end
      grant = g; bus_ready = r;
      #1;
      chk_val("own_busen", bus_en, 32'(g & r));
      chk_val("own_cnt", beat_cnt, k);
      chk_val("own_last", last, 32'(k == len));
      chk_val("own_req", req, 1);
      chk_val("own_done", done, 0);
      if (g & r) k++;
      own_cycles++;
      @(negedge clk);
      cmd_valid = 1'($urandom_range(1));
    end
    chk_val("beats", k, len + 1);
    grant = 1'($urandom_range(1));
    bus_ready = 1'($urandom_range(1));
    #1;
    chk_val("gap_done", done, 1);
    chk_val("gap_req", req, 0);
    chk_val("gap_busy", busy, 1);
    chk_val("gap_ready", cmd_ready, 0);
    chk_val("gap_cnt", beat_cnt, 0);
    chk_val("gap_busen", bus_en, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk_val("end_done", done, 0);
    chk_val("end_ready", cmd_ready, 1);
    chk_val("end_busy", busy, 0);
    chk_val("end_req", req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    logic [8:0] e_req, e_bus, e_done, e_rdy;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; grant = 1'b1; bus_ready = 1'b1;
    #3;
    chk_val("rst_req", req, 0);
    chk_val("rst_cnt", beat_cnt, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_tmo", timeout, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_busen", bus_en, 0);
    chk_val("rst_last", last, 0);
    chk_val("rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(3, 100, 100, -1, 0, 1'b0, oc);
    chk_val("basic_own_cycles", oc, 4);
    run_txn(7, 100, 100, 3, 5, 1'b0, oc);
    chk_val("preempt_own_cycles", oc, 13);
    run_txn(1, 100, 100, 0, 3, 1'b1, oc);
    chk_val("stall_own_cycles", oc, 5);
    run_txn(0, 100, 100, -1, 0, 1'b0, oc);
    chk_val("single_own_cycles", oc, 1);

    // back-to-back single beats with cmd_valid held; bit i is cycle N+i
    e_req  = 9'b001100110;
    e_bus  = 9'b001000100;
    e_done = 9'b010001000;
    e_rdy  = 9'b100010001;
    cmd_valid = 1'b1; cmd_len = '0; grant = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) cmd_valid = 1'b0;
      #1;
      chk_val($sformatf("b2b_req%0d", i), req, 32'(e_req[i]));
      chk_val($sformatf("b2b_busen%0d", i), bus_en, 32'(e_bus[i]));
      chk_val($sformatf("b2b_done%0d", i), done, 32'(e_done[i]));
      chk_val($sformatf("b2b_ready%0d", i), cmd_ready, 32'(e_rdy[i]));
      @(negedge clk);
    end

    for (int t = 0; t < 25; t++) begin
      run_txn($urandom_range(12), 40 + $urandom_range(60), 40 + $urandom_range(60),
              $urandom_range(12), $urandom_range(4), 1'($urandom_range(1)), oc);
    end

    // async reset mid-burst at beat 2
    cmd_valid = 1'b1; cmd_len = 8'd5; grant = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_val("pre_rst_cnt", beat_cnt, 2);
    chk_val("pre_rst_busen", bus_en, 1);
    #2 rst = 1'b1;
    #1;
    chk_val("arst_req", req, 0);
    chk_val("arst_busen", bus_en, 0);
    chk_val("arst_busy", busy, 0);
    chk_val("arst_cnt", beat_cnt, 0);
    chk_val("arst_ready", cmd_ready, 1);
    chk_val("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    chk_val("arst_done_hold", done, 0);
    rst = 1'b0;
    @(negedge clk);
    run_txn(2, 100, 100, -1, 0, 1'b0, oc);
    chk_val("post_rst_own_cycles", oc, 3);

`ifdef ARB_REQ_TIMEOUT_EN
    // grant never comes: expiry on the 16th REQ cycle (index 15)
    grant = 1'b0; cmd_valid = 1'b1; cmd_len = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk_val($sformatf("tw_req%0d", i), req, 1);
      chk_val($sformatf("tw_tmo%0d", i), timeout, 0);
      @(negedge clk);
    end
    chk_val("to_pulse", timeout, 1);
    chk_val("to_req", req, 0);
    chk_val("to_done", done, 0);
    @(negedge clk);
    chk_val("to_clear", timeout, 0);
    chk_val("to_idle", cmd_ready, 1);
    // grant arriving at index 15 wins over expiry
    cmd_valid = 1'b1; cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      grant = (i == 15);
      @(negedge clk);
    end
    grant = 1'b1; bus_ready = 1'b1;
    #1;
    chk_val("tg_tmo", timeout, 0);
    chk_val("tg_req", req, 1);
    chk_val("tg_busen", bus_en, 1);
    @(negedge clk);
    chk_val("tg_done", done, 1);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
